// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM of the multicycle RV32I core; sequences the shared datapath,
// decodes the latched IR, owns the memory req/ack handshake and counts retired instructions.
module multicycle_ctrl #(
   parameter int RET_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ir,
   input  logic             br_taken,
   input  logic             mem_ack,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic [2:0]       imm_sel,
   output logic             alu_a_sel,
   output logic             alu_b_sel,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             retire,
   output logic [RET_W-1:0] ret_cnt,
   output logic             trap,
   output logic [1:0]       trap_cause
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   state_t        state, state_nx;
   logic [1:0]    cause_nx;
   logic [TW-1:0] tmo_cnt;
   logic          legal, d_a, d_b, dec_on, tmo_lim;
   logic [2:0]    d_imm;
   logic [1:0]    d_wb;
   always_comb begin
      legal = 1'b1;
      d_imm = 3'b001;
      d_a   = 1'b0;
      d_b   = 1'b0;
      d_wb  = 2'd0;
      case (ir[6:0])
         OP_LUI:   begin d_imm = 3'b000; d_wb = 2'd3; end
         OP_AUIPC: begin d_imm = 3'b000; d_a = 1'b1; d_b = 1'b1; end
         OP_JAL:   begin d_imm = 3'b111; d_wb = 2'd2; end
         OP_JALR:  d_wb = 2'd2;
         OP_BR:    d_imm = 3'b010;
         OP_LD:    begin d_b = 1'b1; d_wb = 2'd1; end
         OP_ST:    begin d_imm = 3'b110; d_b = 1'b1; end
         OP_IMM:   begin d_imm = (ir[13:12] == 2'b01) ? 3'b011 : 3'b001; d_b = 1'b1; end
         OP_OP:    ;
         default:  begin legal = 1'b0; d_imm = 3'b000; end
      endcase
   end
   assign dec_on    = state inside {DECODE, EXEC, MEM, WB};
   assign imm_sel   = dec_on ? d_imm : 3'b000;
   assign alu_a_sel = dec_on & d_a;
   assign alu_b_sel = dec_on & d_b;
   assign wb_sel    = dec_on ? d_wb : 2'd0;
   assign trap      = state == TRAP;
   // an ack landing on the limit cycle still wins because ack is tested first
   assign tmo_lim   = (MEM_TIMEOUT != 0) && (tmo_cnt == TW'(MEM_TIMEOUT - 1));
   always_comb begin
      state_nx     = state;
      cause_nx     = trap_cause;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      rf_we        = 1'b0;
      retire       = 1'b0;
      case (state)
         FETCH: begin
            mem_req = rst_n;
            if (mem_req && mem_ack) begin
               ir_we    = 1'b1;
               state_nx = DECODE;
            end else if (mem_req && tmo_lim) begin
               state_nx = TRAP;
               cause_nx = 2'd2;
            end
         end
         DECODE: begin
            state_nx = legal ? EXEC : TRAP;
            cause_nx = legal ? trap_cause : 2'd1;
         end
         EXEC: begin
            if (ir[6:0] == OP_BR) begin
               pc_we    = 1'b1;
               pc_src   = br_taken ? 2'd1 : 2'd0;
               retire   = 1'b1;
               state_nx = FETCH;
            end else
               state_nx = (ir[6:0] == OP_LD || ir[6:0] == OP_ST) ? MEM : WB;
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = ir[6:0] == OP_ST;
            if (mem_ack) begin
               pc_we    = mem_we;
               retire   = mem_we;
               state_nx = mem_we ? FETCH : WB;
            end else if (tmo_lim) begin
               state_nx = TRAP;
               cause_nx = 2'd2;
            end
         end
         WB: begin
            rf_we    = ir[11:7] != 5'd0;
            pc_we    = 1'b1;
            pc_src   = (ir[6:0] == OP_JAL) ? 2'd1 : (ir[6:0] == OP_JALR) ? 2'd2 : 2'd0;
            retire   = 1'b1;
            state_nx = FETCH;
         end
         default: state_nx = TRAP;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         trap_cause <= 2'd0;
         ret_cnt    <= '0;
         tmo_cnt    <= '0;
      end else begin
         state      <= state_nx;
         trap_cause <= cause_nx;
         ret_cnt    <= ret_cnt + RET_W'(retire);
         tmo_cnt    <= (mem_req && !mem_ack) ? tmo_cnt + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle schedules built from the instruction semantics,
// compared against the controller every cycle, plus directed literal pins and random traffic.
module tb_multicycle_ctrl;
   localparam int RW  = 4;
   localparam int TMO = 4;
   localparam logic [2:0] K_ALU = 3'd0, K_BR = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_JAL = 3'd4, K_JALR = 3'd5;
   typedef struct packed {
      logic       ir_we, pc_we;
      logic [1:0] pc_src;
      logic [2:0] imm_sel;
      logic       a_sel, b_sel, mem_req, mem_we, mem_addr_sel, rf_we;
      logic [1:0] wb_sel;
      logic       retire, trap;
      logic [1:0] cause;
   } ov_t;
   typedef struct packed {
      logic [31:0] ir;
      logic        ack, br;
      ov_t         e;
   } cyc_t;
   typedef struct packed {
      logic       legal;
      logic [2:0] kind, imm;
      logic       a, b;
      logic [1:0] wb;
   } dec_t;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [31:0] ir = 32'd0;
   logic br_taken = 1'b0, mem_ack = 1'b0;
   logic ir_we, pc_we, alu_a_sel, alu_b_sel, mem_req, mem_we, mem_addr_sel, rf_we, retire, trap;
   logic [1:0] pc_src, wb_sel, trap_cause;
   logic [2:0] imm_sel;
   logic [RW-1:0] ret_cnt;
   ov_t dut_v, exp_v;
   logic chk_en = 1'b0;
   logic [RW-1:0] m_ret = '0;
   logic m_trap = 1'b0;
   logic [1:0] m_cause = 2'd0;
   cyc_t sched[$];
   int checks = 0, failures = 0;
   multicycle_ctrl #(.RET_W(RW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .br_taken(br_taken), .mem_ack(mem_ack),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire),
      .ret_cnt(ret_cnt), .trap(trap), .trap_cause(trap_cause));
   always #5 clk = ~clk;
   assign dut_v = {ir_we, pc_we, pc_src, imm_sel, alu_a_sel, alu_b_sel, mem_req, mem_we,
                   mem_addr_sel, rf_we, wb_sel, retire, trap, trap_cause};
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask
   always @(negedge clk) if (chk_en) begin
      check("cycle_outputs", 32'(dut_v), 32'(exp_v));
      check("cycle_ret_cnt", 32'(ret_cnt), 32'(m_ret));
   end
   // instruction semantics table: class, immediate format, operand and writeback selects
   function automatic dec_t dec(input logic [31:0] i);
      dec_t d;
      d = '0;
      d.legal = 1'b1;
      d.imm = 3'b001;
      case (i[6:0])
         7'b0110111: begin d.kind = K_ALU; d.imm = 3'b000; d.wb = 2'd3; end
         7'b0010111: begin d.kind = K_ALU; d.imm = 3'b000; d.a = 1'b1; d.b = 1'b1; end
         7'b1101111: begin d.kind = K_JAL; d.imm = 3'b111; d.wb = 2'd2; end
         7'b1100111: begin d.kind = K_JALR; d.wb = 2'd2; end
         7'b1100011: begin d.kind = K_BR; d.imm = 3'b010; end
         7'b0000011: begin d.kind = K_LD; d.b = 1'b1; d.wb = 2'd1; end
         7'b0100011: begin d.kind = K_ST; d.imm = 3'b110; d.b = 1'b1; end
         7'b0010011: begin
            d.kind = K_ALU; d.b = 1'b1;
            d.imm = (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'b011 : 3'b001;
         end
         7'b0110011: d.kind = K_ALU;
         default: begin d.legal = 1'b0; d.imm = 3'b000; end
      endcase
      return d;
   endfunction
   task automatic push(input logic [31:0] i, input logic a, input logic br, input ov_t e);
      cyc_t c;
      c.ir = i; c.ack = a; c.br = br; c.e = e;
      sched.push_back(c);
   endtask
   task automatic tail(input logic [31:0] i, input logic br);
      ov_t t;
      t = '0; t.trap = 1'b1; t.cause = m_cause;
      for (int k = 0; k < 3; k++) push(i, 1'($urandom), br, t);
   endtask
   task automatic mem_phase(input logic [31:0] i, input logic br, input ov_t base, input ov_t on_ack,
                            input int waits, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         if (c == waits) begin
            push(i, 1'b1, br, base | on_ack);
            ok = 1'b1;
            return;
         end
         push(i, 1'b0, br, base);
      end
      m_trap = 1'b1; m_cause = 2'd2;
      tail(i, br);
   endtask
   task automatic build(input logic [31:0] i, input logic br, input int fw, input int mw);
      dec_t d;
      ov_t z, s, f, fa, e, m, ma, w;
      bit ok;
      d = dec(i);
      z = '0; z.trap = m_trap; z.cause = m_cause;
      if (m_trap) begin tail(i, br); return; end
      s = z; s.imm_sel = d.imm; s.a_sel = d.a; s.b_sel = d.b; s.wb_sel = d.wb;
      f = z; f.mem_req = 1'b1;
      fa = '0; fa.ir_we = 1'b1;
      mem_phase(i, br, f, fa, fw, ok);
      if (!ok) return;
      push(i, 1'($urandom), br, s);
      if (!d.legal) begin m_trap = 1'b1; m_cause = 2'd1; tail(i, br); return; end
      e = s;
      if (d.kind == K_BR) begin
         e.pc_we = 1'b1; e.pc_src = br ? 2'd1 : 2'd0; e.retire = 1'b1;
         push(i, 1'($urandom), br, e);
         return;
      end
      push(i, 1'($urandom), br, e);
      if (d.kind == K_LD || d.kind == K_ST) begin
         m = s; m.mem_req = 1'b1; m.mem_addr_sel = 1'b1; m.mem_we = d.kind == K_ST;
         ma = '0; ma.pc_we = d.kind == K_ST; ma.retire = d.kind == K_ST;
         mem_phase(i, br, m, ma, mw, ok);
         if (!ok || d.kind == K_ST) return;
      end
      w = s; w.rf_we = i[11:7] != 5'd0; w.pc_we = 1'b1; w.retire = 1'b1;
      w.pc_src = (d.kind == K_JAL) ? 2'd1 : (d.kind == K_JALR) ? 2'd2 : 2'd0;
      push(i, 1'($urandom), br, w);
   endtask
   task automatic play();
      cyc_t c;
      while (sched.size() > 0) begin
         c = sched.pop_front();
         ir = c.ir; mem_ack = c.ack; br_taken = c.br; exp_v = c.e; chk_en = 1'b1;
         @(posedge clk);
         #1;
         if (c.e.retire) m_ret++;
      end
      mem_ack = 1'b0;
   endtask
   task automatic do_reset();
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mem_req_drop", 32'(mem_req), 32'd0);
      check("rst_ret_cnt", 32'(ret_cnt), 32'd0);
      check("rst_trap", 32'({trap, trap_cause}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      m_ret = '0; m_trap = 1'b0; m_cause = 2'd0;
   endtask
   initial begin
      logic [6:0] ops [9];
      logic [31:0] r, i;
      logic [6:0] op;
      int fw, mw;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      @(posedge clk);
      #1;
      do_reset();
      build(32'h00500093, 1'b0, 0, 0);
      check("addi_len", 32'(sched.size()), 32'd4);
      check("addi_imm_sel", 32'(sched[1].e.imm_sel), 32'd1);
      check("addi_b_sel", 32'(sched[1].e.b_sel), 32'd1);
      check("addi_rf_we_c4", 32'(sched[3].e.rf_we), 32'd1);
      check("addi_retire_c4", 32'(sched[3].e.retire), 32'd1);
      play();
      check("addi_ret_cnt", 32'(ret_cnt), 32'd1);
      build(32'h00008463, 1'b1, 0, 0);
      check("beq_t_pc_we", 32'(sched[2].e.pc_we), 32'd1);
      check("beq_t_pc_src", 32'(sched[2].e.pc_src), 32'd1);
      check("beq_imm_sel", 32'(sched[2].e.imm_sel), 32'd2);
      play();
      build(32'h00008463, 1'b0, 1, 0);
      check("beq_nt_len", 32'(sched.size()), 32'd4);
      check("beq_nt_pc_src", 32'(sched[3].e.pc_src), 32'd0);
      check("beq_nt_rf_we", 32'(sched[3].e.rf_we), 32'd0);
      play();
      build(32'h0040A103, 1'b0, 0, 3);
      check("lw_len", 32'(sched.size()), 32'd8);
      check("lw_mem_wait", 32'({sched[4].e.mem_req, sched[4].e.mem_addr_sel, sched[4].ack}), 32'd6);
      check("lw_wb", 32'({sched[7].e.wb_sel, sched[7].e.rf_we}), 32'd3);
      play();
      build(32'h00209093, 1'b0, 0, 0);
      check("slli_imm_sel", 32'(sched[1].e.imm_sel), 32'd3);
      play();
      check("dir_ret_cnt", 32'(ret_cnt), 32'd5);
      build(32'hFFFFFFFF, 1'b0, 0, 0);
      play();
      check("illegal_trap", 32'({trap, trap_cause, mem_req}), 32'b1010);
      do_reset();
      build(32'h00500093, 1'b0, 10, 0);
      play();
      check("fetch_tmo_trap", 32'({trap, trap_cause}), 32'b110);
      do_reset();
      build(32'h00500093, 1'b0, 3, 0);
      play();
      check("fetch_ack_at_limit", 32'({trap, ret_cnt}), 32'd1);
      do_reset();
      for (int n = 0; n < 16; n++) begin
         build(32'h0020A023, 1'b0, $urandom_range(0, 1), $urandom_range(0, 3));
         play();
      end
      check("sw_wrap_ret_cnt", 32'(ret_cnt), 32'd0);
      build(32'h0020A023, 1'b0, 0, 9);
      play();
      check("mem_tmo_trap", 32'({trap, trap_cause}), 32'b110);
      do_reset();
      for (int n = 0; n < 250; n++) begin
         r = $urandom();
         op = ($urandom_range(0, 15) == 0) ? 7'(r) : ops[$urandom_range(0, 8)];
         i = {r[31:7], op};
         fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
         build(i, 1'($urandom), fw, mw);
         play();
         if (m_trap) do_reset();
      end
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
